// File: rtl/hann_frame_pkg.sv
// Shared parameters and types for the Hanning frame sequencer.
// The overlapped frame geometry lives here so that the RAM and the sequencer agree on it.
package hann_frame_pkg;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 256;
  localparam int HOP       = 128;
  localparam int ADDR_W    = 9;
  localparam int DEPTH     = 2 * FRAME_LEN;

  typedef enum logic {IDLE, READ} seq_state_t;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/frame_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// No reset on the array or the read register, so it maps onto block RAM.
module frame_sample_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/hann_frame_sequencer.sv
// Buffers the audio stream and replays 50%-overlapped frames as gap-free bursts
// into the Hanning window, with sof/eof markers aligned to the window product.
module hann_frame_sequencer #(
  parameter int DATA_W    = hann_frame_pkg::DATA_W,
  parameter int FRAME_LEN = hann_frame_pkg::FRAME_LEN,
  parameter int HOP       = hann_frame_pkg::HOP,
  parameter int ADDR_W    = hann_frame_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              vld_in,
  input  logic              fft_rdy,
  output logic [DATA_W-1:0] win_audio,
  output logic              win_vld,
  output logic              fft_sof,
  output logic              fft_eof,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_cnt
);

  import hann_frame_pkg::*;

  localparam int FILL_W = $clog2(FRAME_LEN + 1);
  localparam int HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int IDX_W  = $clog2(FRAME_LEN);

  seq_state_t state;
  seq_state_t next_state;

  logic [ADDR_W-1:0] wr_ptr;
  logic [FILL_W-1:0] fill_cnt;
  logic [HOP_W-1:0]  hop_cnt;
  logic              pending;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] rd_base;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic wr_en;
  logic primed;
  logic req;
  logic launch;
  logic rd_en;
  logic rd_first;
  logic rd_last;
  logic first_d;
  logic last_d;

  assign wr_en  = vld_in && !rst;
  assign primed = (fill_cnt == FILL_W'(FRAME_LEN));
  assign req    = wr_en && (primed ? (hop_cnt == HOP_W'(HOP - 1))
                                   : (fill_cnt == FILL_W'(FRAME_LEN - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
    end else if (vld_in) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (!primed) begin
        fill_cnt <= fill_cnt + FILL_W'(1);
      end else if (hop_cnt == HOP_W'(HOP - 1)) begin
        hop_cnt <= '0;
      end else begin
        hop_cnt <= hop_cnt + HOP_W'(1);
      end
    end
  end

  // A new request always wins over clearing, so a launch in the same cycle keeps the fresh base.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      req_base <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= req && pending && !launch;
      if (req) begin
        pending  <= 1'b1;
        req_base <= wr_ptr + ADDR_W'(1) - ADDR_W'(FRAME_LEN);
      end else if (launch) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (pending && fft_rdy) next_state = READ;
      READ: if (rd_idx == IDX_W'(FRAME_LEN - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    launch   = (state == IDLE) && pending && fft_rdy;
    rd_en    = (state == READ);
    rd_first = rd_en && (rd_idx == '0);
    rd_last  = rd_en && (rd_idx == IDX_W'(FRAME_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_base <= '0;
      rd_idx  <= '0;
    end else if (launch) begin
      rd_base <= req_base;
      rd_idx  <= '0;
    end else if (rd_en) begin
      rd_idx <= rd_idx + IDX_W'(1);
    end
  end

  assign rd_addr = rd_base + ADDR_W'(rd_idx);

  frame_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (audio_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Markers ride one stage behind win_vld to line up with the window's product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld   <= 1'b0;
      first_d   <= 1'b0;
      last_d    <= 1'b0;
      fft_sof   <= 1'b0;
      fft_eof   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      win_vld <= rd_en;
      first_d <= rd_first;
      last_d  <= rd_last;
      fft_sof <= first_d;
      fft_eof <= last_d;
      if (fft_eof) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign win_audio = win_vld ? rd_data : '0;
  assign busy      = rd_en || win_vld;

endmodule
